// File: rtl/rv_pkg.sv
// Shared RV32I memory-interface definitions: funct3 access sizes, arbiter states, XLEN default.
package rv_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [2:0] MEM_B  = 3'b000;
  localparam logic [2:0] MEM_H  = 3'b001;
  localparam logic [2:0] MEM_W  = 3'b010;
  localparam logic [2:0] MEM_BU = 3'b100;
  localparam logic [2:0] MEM_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for one single-port memory bus, data-priority with fetch starvation guard.
// Optional bus timeout abort enabled by defining MEM_ARBITER_TIMEOUT_EN.
module mem_arbiter
  import rv_pkg::*;
#(
  parameter int XLEN        = XLEN_DEFAULT,
  parameter int STARVE_MAX  = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_ack,
  output logic [XLEN-1:0] if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  input  logic [2:0]      d_memCtrl,
  output logic            d_ack,
  output logic [XLEN-1:0] d_rdata,
  output logic            bus_valid,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [XLEN-1:0] bus_wdata,
  output logic [2:0]      bus_size,
  input  logic            bus_ready,
  input  logic [XLEN-1:0] bus_rdata,
  output logic            grant,
  output logic            busy,
  output logic            bus_err
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  if (STARVE_MAX < 1 || TIMEOUT_CYC < 1) begin : g_bad_param
    $error("mem_arbiter: STARVE_MAX and TIMEOUT_CYC must be at least 1");
  end

  arb_state_t      state_q;
  logic [SW-1:0]   starve_q, starve_d;
  logic            fetch_win;
  logic            bus_valid_q, bus_we_q, grant_q, busy_q, if_ack_q, d_ack_q;
  logic [XLEN-1:0] bus_addr_q, bus_wdata_q, if_rdata_q, d_rdata_q;
  logic [2:0]      bus_size_q;

`ifdef MEM_ARBITER_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  logic [TW-1:0] wait_q;
  logic          bus_err_q;
  assign bus_err = bus_err_q;
`else
  assign bus_err = 1'b0;
`endif

  // A data win with if_req set implies starve_q < STARVE_MAX, so the increment saturates naturally.
  always_comb begin
    fetch_win = if_req && (!d_req || starve_q == SW'(STARVE_MAX));
    starve_d  = starve_q;
    if (state_q == IDLE) begin
      if (fetch_win)            starve_d = '0;
      else if (d_req && if_req) starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      bus_valid_q <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      bus_size_q  <= '0;
      grant_q     <= 1'b0;
      busy_q      <= 1'b0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
`ifdef MEM_ARBITER_TIMEOUT_EN
      wait_q      <= '0;
      bus_err_q   <= 1'b0;
`endif
    end else begin
      if_ack_q <= 1'b0;
      d_ack_q  <= 1'b0;
`ifdef MEM_ARBITER_TIMEOUT_EN
      bus_err_q <= 1'b0;
`endif
      starve_q <= starve_d;
      case (state_q)
        IDLE: begin
          if (fetch_win) begin
            bus_valid_q <= 1'b1;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= if_addr;
            bus_wdata_q <= '0;
            bus_size_q  <= MEM_W;
            grant_q     <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= BUSY;
`ifdef MEM_ARBITER_TIMEOUT_EN
            wait_q      <= '0;
`endif
          end else if (d_req) begin
            bus_valid_q <= 1'b1;
            bus_we_q    <= d_we;
            bus_addr_q  <= d_addr;
            bus_wdata_q <= d_wdata;
            bus_size_q  <= d_memCtrl;
            grant_q     <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= BUSY;
`ifdef MEM_ARBITER_TIMEOUT_EN
            wait_q      <= '0;
`endif
          end
        end
        BUSY: begin
          if (bus_ready) begin
            bus_valid_q <= 1'b0;
            if (grant_q) begin
              d_rdata_q <= bus_rdata;
              d_ack_q   <= 1'b1;
            end else begin
              if_rdata_q <= bus_rdata;
              if_ack_q   <= 1'b1;
            end
            state_q <= RESP;
          end
`ifdef MEM_ARBITER_TIMEOUT_EN
          else if (wait_q == TW'(TIMEOUT_CYC - 1)) begin
            bus_valid_q <= 1'b0;
            bus_err_q   <= 1'b1;
            if (grant_q) begin
              d_rdata_q <= '0;
              d_ack_q   <= 1'b1;
            end else begin
              if_rdata_q <= '0;
              if_ack_q   <= 1'b1;
            end
            state_q <= RESP;
          end else begin
            wait_q <= wait_q + TW'(1);
          end
`endif
        end
        RESP: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign if_ack    = if_ack_q;
  assign if_rdata  = if_rdata_q;
  assign d_ack     = d_ack_q;
  assign d_rdata   = d_rdata_q;
  assign bus_valid = bus_valid_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_size  = bus_size_q;
  assign grant     = grant_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level model checked every cycle plus directed literal checks.
// Define MEM_ARBITER_TIMEOUT_EN for both RTL and bench to exercise the timeout abort.
module tb_mem_arbiter;
  import rv_pkg::*;

  localparam int XL    = 32;
  localparam int SMAX  = 4;
  localparam int TB_TO = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [XL-1:0] if_addr = '0, d_addr = '0, d_wdata = '0;
  logic [2:0]    d_memCtrl = '0;
  logic          if_ack, d_ack, bus_valid, bus_we, grant, busy, bus_err;
  logic [XL-1:0] if_rdata, d_rdata, bus_addr, bus_wdata, bus_rdata;
  logic [2:0]    bus_size;
  logic          bus_ready = 1'b0;

  logic          stall = 1'b0;
  int            delay = 0;
  int            vcnt = 0;
  logic          rd_ovr_en = 1'b0;
  logic [XL-1:0] rd_ovr = '0;

  int checks = 0;
  int failures = 0;

  assign bus_rdata = rd_ovr_en ? rd_ovr : {bus_addr[15:0], 16'h5A5A};

  mem_arbiter #(.XLEN(XL), .STARVE_MAX(SMAX), .TIMEOUT_CYC(TB_TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_memCtrl(d_memCtrl),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .bus_valid(bus_valid), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_size(bus_size), .bus_ready(bus_ready), .bus_rdata(bus_rdata),
    .grant(grant), .busy(busy), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=0x%08h required=0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(output logic got_d, output logic got_i, input int budget);
    got_d = 1'b0;
    got_i = 1'b0;
    for (int n = 0; n < budget; n++) begin
      tick();
      if (d_ack || if_ack) begin
        got_d = d_ack;
        got_i = if_ack;
        return;
      end
    end
    checks++;
    failures++;
    $display("FAIL ack_wait: actual=no ack within %0d cycles required=one ack", budget);
  endtask

  // Slave: raises ready once bus_valid has been seen for `delay` cycles, unless stalled.
  initial forever begin
    @(posedge clk);
    #1;
    if (!bus_valid) begin
      vcnt = 0;
      bus_ready = 1'b0;
    end else begin
      bus_ready = !stall && (vcnt >= delay);
      vcnt++;
    end
  end

  // Transaction-level model: one transaction in flight, one ack cycle, then free to arbitrate.
  logic          m_valid = 0, m_we = 0, m_grant = 0, m_busy = 0, m_owner_d = 0;
  logic          m_if_ack = 0, m_d_ack = 0, m_err = 0;
  logic [XL-1:0] m_addr = '0, m_wdata = '0, m_if_rdata = '0, m_d_rdata = '0;
  logic [2:0]    m_size = '0;
  int            m_streak = 0, m_wait = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 0; m_we <= 0; m_grant <= 0; m_busy <= 0; m_owner_d <= 0;
      m_if_ack <= 0; m_d_ack <= 0; m_err <= 0;
      m_addr <= '0; m_wdata <= '0; m_if_rdata <= '0; m_d_rdata <= '0; m_size <= '0;
      m_streak <= 0; m_wait <= 0;
    end else begin
      m_if_ack <= 0;
      m_d_ack  <= 0;
      m_err    <= 0;
      if (m_if_ack || m_d_ack) begin
        m_busy <= 0;
      end else if (m_valid) begin
        if (bus_ready) begin
          m_valid <= 0;
          if (m_owner_d) begin m_d_ack <= 1; m_d_rdata <= bus_rdata; end
          else begin m_if_ack <= 1; m_if_rdata <= bus_rdata; end
        end else begin
          m_wait <= m_wait + 1;
`ifdef MEM_ARBITER_TIMEOUT_EN
          if (m_wait + 1 == TB_TO) begin
            m_valid <= 0;
            m_err   <= 1;
            if (m_owner_d) begin m_d_ack <= 1; m_d_rdata <= '0; end
            else begin m_if_ack <= 1; m_if_rdata <= '0; end
          end
`endif
        end
      end else if (!m_busy) begin
        if (if_req && (!d_req || m_streak >= SMAX)) begin
          m_valid <= 1; m_busy <= 1; m_owner_d <= 0; m_grant <= 0; m_wait <= 0;
          m_we <= 0; m_addr <= if_addr; m_wdata <= '0; m_size <= 3'b010;
          m_streak <= 0;
        end else if (d_req) begin
          m_valid <= 1; m_busy <= 1; m_owner_d <= 1; m_grant <= 1; m_wait <= 0;
          m_we <= d_we; m_addr <= d_addr; m_wdata <= d_wdata; m_size <= d_memCtrl;
          if (if_req) m_streak <= (m_streak < SMAX) ? m_streak + 1 : SMAX;
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    chk("bus_valid", bus_valid, m_valid);
    chk("bus_we", bus_we, m_we);
    chk("bus_addr", bus_addr, m_addr);
    chk("bus_wdata", bus_wdata, m_wdata);
    chk("bus_size", bus_size, m_size);
    chk("grant", grant, m_grant);
    chk("busy", busy, m_busy);
    chk("if_ack", if_ack, m_if_ack);
    chk("d_ack", d_ack, m_d_ack);
    chk("if_rdata", if_rdata, m_if_rdata);
    chk("d_rdata", d_rdata, m_d_rdata);
    chk("bus_err", bus_err, m_err);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

  logic       gd, gi;
  logic [9:0] seq;

  initial begin
    seq = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bus_valid", bus_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_acks", {if_ack, d_ack}, 0);
    chk("rst_bus_addr", bus_addr, 0);
    rst_n = 1'b1;
    tick();

    // Fetch only, zero-wait slave
    rd_ovr_en = 1; rd_ovr = 32'h0000_0013; delay = 0;
    if_addr = 32'h0000_0040; if_req = 1;
    tick();
    chk("t1_valid", bus_valid, 1);
    chk("t1_addr", bus_addr, 32'h40);
    chk("t1_size", bus_size, 3'b010);
    chk("t1_we", bus_we, 0);
    chk("t1_grant", grant, 0);
    tick();
    chk("t1_if_ack", if_ack, 1);
    chk("t1_if_rdata", if_rdata, 32'h13);
    chk("t1_d_ack", d_ack, 0);
    if_req = 0; rd_ovr_en = 0;
    tick();
    chk("t1_idle", busy, 0);

    // Byte store with a 3-cycle ready delay
    delay = 3; d_req = 1; d_we = 1; d_addr = 32'h1000; d_wdata = 32'hDEAD_BEEF; d_memCtrl = MEM_B;
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk("t2_valid", bus_valid, 1);
      chk("t2_addr", bus_addr, 32'h1000);
      chk("t2_wdata", bus_wdata, 32'hDEAD_BEEF);
      chk("t2_size", bus_size, 3'b000);
      chk("t2_we", bus_we, 1);
      chk("t2_no_ack", {if_ack, d_ack}, 0);
    end
    tick();
    chk("t2_d_ack", d_ack, 1);
    chk("t2_grant", grant, 1);
    chk("t2_if_ack", if_ack, 0);
    d_req = 0; d_we = 0; delay = 0;
    tick();

    // Both held: starvation guard forces every fifth grant to fetch
    if_addr = 32'h80; d_addr = 32'h2000; d_memCtrl = MEM_W; if_req = 1; d_req = 1;
    for (int k = 0; k < 10; k++) begin
      wait_ack(gd, gi, 10);
      seq = {seq[8:0], gd};
    end
    if_req = 0; d_req = 0;
    chk("t3_grant_seq", {22'd0, seq}, {22'd0, 10'b1111011110});
    tick(); tick();

    // Simultaneous requests: data first, fetch next once d_req drops
    if_addr = 32'hC0; d_addr = 32'h2004; if_req = 1; d_req = 1;
    wait_ack(gd, gi, 10);
    chk("t4_first_data", gd, 1);
    chk("t4_first_not_fetch", gi, 0);
    chk("t4_load_rdata", d_rdata, 32'h2004_5A5A);
    d_req = 0;
    wait_ack(gd, gi, 10);
    chk("t4_then_fetch", gi, 1);
    if_req = 0;
    tick(); tick();

    // Reset while a transaction is stalled on the bus
    stall = 1; d_req = 1; d_we = 1; d_addr = 32'h4000; d_wdata = 32'h1234_5678; d_memCtrl = MEM_W;
    tick();
    chk("t5_valid", bus_valid, 1);
    chk("t5_busy", busy, 1);
    #2 rst_n = 0;
    #1;
    chk("t5_valid_async", bus_valid, 0);
    chk("t5_busy_async", busy, 0);
    chk("t5_acks_async", {if_ack, d_ack}, 0);
    d_req = 0; d_we = 0; stall = 0;
    tick(); tick();
    rst_n = 1;
    repeat (4) begin
      tick();
      chk("t5_no_ack", {if_ack, d_ack}, 0);
      chk("t5_stay_idle", busy, 0);
    end

    // Normal load, then a load the slave never answers
    d_req = 1; d_addr = 32'h3000; d_memCtrl = MEM_W;
    wait_ack(gd, gi, 10);
    chk("t6_load_rdata", d_rdata, 32'h3000_5A5A);
    d_req = 0;
    tick();
    stall = 1; d_req = 1; d_addr = 32'h3004;
`ifdef MEM_ARBITER_TIMEOUT_EN
    for (int c = 1; c <= 8; c++) begin
      tick();
      chk("t6_valid_held", bus_valid, 1);
      chk("t6_no_err_yet", bus_err, 0);
    end
    tick();
    chk("t6_valid_drop", bus_valid, 0);
    chk("t6_abort_ack", d_ack, 1);
    chk("t6_bus_err", bus_err, 1);
    chk("t6_abort_rdata", d_rdata, 0);
    chk("t6_if_ack", if_ack, 0);
    d_req = 0; stall = 0;
    tick();
`else
    for (int c = 1; c <= 12; c++) begin
      tick();
      chk("t6_valid_held", bus_valid, 1);
      chk("t6_no_err", bus_err, 0);
    end
    stall = 0;
    wait_ack(gd, gi, 6);
    chk("t6_late_ack", gd, 1);
    chk("t6_late_no_err", bus_err, 0);
    chk("t6_late_rdata", d_rdata, 32'h3004_5A5A);
    d_req = 0;
    tick();
`endif
    tick(); tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
